// File: rtl/onehot_pkg.sv
// onehot_pkg: shared FSM state type and lowest-set-bit helper
// for the one-hot serializer and decoder-side benches.
package onehot_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MAX_N = 32;

  function automatic int lowest_bit_index(
    input logic [MAX_N-1:0] v
  );
    lowest_bit_index = 0;
    // scan downward so the lowest set bit wins
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit_index = i;
    end
  endfunction

endpackage

// File: rtl/onehot_serializer_prio_enc.sv
// prio_enc: combinational lowest-set-bit priority encoder.
// idx is 0 when vec is 0; any flags a non-empty vector.
module prio_enc
  import onehot_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [MAX_N-1:0] ext;

  assign ext = MAX_N'(vec);
  assign idx = W'(lowest_bit_index(ext));
  assign any = |vec;

endmodule

// File: rtl/onehot_serializer.sv
// onehot_serializer: captures a multi-hot vector and emits the
// index of each set bit, lowest first, over valid/ready.
module onehot_serializer
  import onehot_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic         out_last,
  input  logic         out_ready
);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pending;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] rest;
  logic [W-1:0] idx;
  logic         any;

  prio_enc #(.N(N)) u_enc (
    .vec (pending),
    .idx (idx),
    .any (any)
  );

  assign rest = pending & (pending - N'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // outputs depend on registered state only
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out         = '0;
    out_last    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (|in)) begin
          pending_nxt = in;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        out       = idx;
        out_last  = any && (rest == '0);
        if (out_ready) begin
          pending_nxt = rest;
          if (rest == '0) state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_serializer.sv
// tb_onehot_serializer: scoreboard bench for onehot_serializer.
// Expected beats queued at drive time, popped on handshakes.
module tb_onehot_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in = '0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out;
  logic       out_last;
  logic       out_ready = 1'b0;

  int checks = 0;
  int passed = 0;
  int mchecks = 0;
  int mpassed = 0;
  int beats = 0;
  bit rand_rdy = 1'b0;

  logic [3:0] q[$];

  onehot_serializer #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && !out_valid) begin
      mchecks++;
      if ({out, out_last} !== 4'b0)
        $display("FAIL idle_zero out=%0d last=%0b want 0 0",
                 out, out_last);
      else mpassed++;
    end
    if (!rst && out_valid && out_ready) begin
      mchecks++;
      beats++;
      if (q.size() == 0) begin
        $display("FAIL beat_unexpected out=%0d last=%0b want none",
                 out, out_last);
      end else begin
        e = q.pop_front();
        if ({out, out_last} !== e)
          $display("FAIL beat out=%0d last=%0b want %0d %0b",
                   out, out_last, e[3:1], e[0]);
        else mpassed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    int top = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
    end
    for (int i = 0; i < 8; i++) if (v[i]) top = i;
    for (int i = 0; i < 8; i++)
      if (v[i]) q.push_back({3'(i), i == top});
    in_valid = 1'b1;
    in = v;
    step();
    in_valid = 1'b0;
    in = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0 || !in_ready)
      $display("FAIL drain left=%0d in_ready=%0b want 0 1",
               q.size(), in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out, out_last} !== 6'b10_0000)
      $display("FAIL reset rdy=%0b vld=%0b out=%0d last=%0b want 1 0 0 0",
               in_ready, out_valid, out, out_last);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(8'b0010_0000);
    checks++;
    if ({out_valid, out, out_last} !== {1'b1, 3'd5, 1'b1})
      $display("FAIL single vld=%0b out=%0d last=%0b want 1 5 1",
               out_valid, out, out_last);
    else passed++;
    step();
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL single_turn in_ready=%0b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_burst();
    out_ready = 1'b1;
    send(8'b1001_0110);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL burst_rate rdy=%0b vld=%0b want 1 0",
               in_ready, out_valid);
    else passed++;
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'b0000_1001);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out, out_last} !== {1'b1, 3'd0, 1'b0})
        $display("FAIL hold vld=%0b out=%0d last=%0b want 1 0 0",
                 out_valid, out, out_last);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out, out_last} !== {1'b1, 3'd3, 1'b1})
      $display("FAIL bp_last vld=%0b out=%0d last=%0b want 1 3 1",
               out_valid, out, out_last);
    else passed++;
    drain();
  endtask

  task automatic test_zero_busy();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in = 8'h00;
    step();
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL zero rdy=%0b vld=%0b want 1 0",
               in_ready, out_valid);
    else passed++;
    out_ready = 1'b0;
    send(8'h03);
    in_valid = 1'b1;
    in = 8'hFF;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL busy_in rdy=%0b vld=%0b out=%0d want 0 1 0",
               in_ready, out_valid, out);
    else passed++;
    in_valid = 1'b0;
    in = '0;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_full_reset();
    out_ready = 1'b1;
    send(8'hFF);
    drain();
    send(8'hFF);
    step();
    step();
    step();
    checks++;
    if (q.size() !== 5 || out !== 3'd3)
      $display("FAIL pre_rst left=%0d out=%0d want 5 3", q.size(), out);
    else passed++;
    rst = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, out, out_last} !== 6'b10_0000)
      $display("FAIL mid_rst rdy=%0b vld=%0b out=%0d last=%0b want 1 0 0 0",
               in_ready, out_valid, out, out_last);
    else passed++;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_exhaustive();
    beats = 0;
    rand_rdy = 1'b1;
    for (int v = 1; v < 256; v++) send(8'(v));
    drain();
    rand_rdy = 1'b0;
    checks++;
    if (beats !== 1024)
      $display("FAIL exh_beats got=%0d want 1024", beats);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_zero_busy();
    test_full_reset();
    test_exhaustive();
    step();
    $display("%0d/%0d checks passed", passed + mpassed, checks + mchecks);
    $finish;
  end

endmodule

// File: doc/onehot_serializer.md
# onehot_serializer

Sequential encoder that turns a multi-hot request vector into a stream of binary indices, one per accepted output beat, lowest set bit first. Inverse of the team's binary-to-one-hot decoder: the decoder fans an index out to a line, this block collapses lines back into indices. It sits between request sources (interrupt lines, per-channel flags) and a consumer that handles one index at a time, with valid/ready handshakes on both sides.

## Interface
- N, default 8: width of the request vector; N ≥ 2.
- W, default $clog2(N): index width; derived, not overridden.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  request vector present on `in`.
- in  in  N  multi-hot request vector.
- in_ready  out  1  block can capture a vector this cycle.
- out_valid  out  1  `out` holds a valid index.
- out  out  W  binary index of the lowest pending bit.
- out_last  out  1  current index is the final pending bit of the captured vector.
- out_ready  in  1  consumer accepts `out` this cycle.

## Operation
- State machine: IDLE, BUSY.
- State register `pending[N-1:0]`.
- IDLE:
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid` with `in` ≠ 0: `pending` <= `in`, go to BUSY.
  - On `in_valid` with `in` = 0: the vector is accepted and dropped. No output is produced and the state stays IDLE.
- BUSY:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out` = index of the lowest set bit of `pending`.
  - `out_last` = 1 exactly when `pending` has one bit set.
- On `out_ready` in BUSY:
  - Clear the lowest set bit: `pending` <= `pending & (pending - 1)`, width N, no carry out.
  - If `out_last`, go to IDLE.
- `out_ready` high with `out_valid` low has no effect.
- While `out_valid` = 1 and `out_ready` = 0, `out` and `out_last` hold stable. The data does not change under valid.
- `in_valid` during BUSY is ignored because `in_ready` = 0. The producer must hold its vector until it is accepted.
- Reset values:
  - state IDLE, `pending` = 0.
  - `in_ready` = 1, `out_valid` = 0, `out` = 0, `out_last` = 0.
- Reset mid-burst:
  - Any remaining pending bits are discarded.
  - The next cycle is IDLE with the reset values above.
  - An index that was presented but not accepted before reset is lost.
- `out` and `out_last` read 0 whenever `out_valid` = 0.

## Timing
- Capture latency: a vector accepted at edge k presents its first index with `out_valid` = 1 in the cycle after k.
- Throughput:
  - One index per cycle while `out_ready` is held high.
  - A vector with p set bits occupies BUSY for p accepted beats.
- Turnaround:
  - After the `out_last` beat is accepted, `in_ready` = 1 in the next cycle.
  - Minimum cost is one idle cycle between vectors, so N-bit all-ones takes N+1 cycles per vector.
- No combinational path from `in_valid` or `in` to any output:
  - `in_ready`, `out_valid`, `out` and `out_last` are functions of registered state only.
- `out_ready` affects next state only. It has no combinational effect on outputs.

## Structure
- Package `onehot_pkg`: the state enum type (IDLE, BUSY) and a `popcount`-free helper function `lowest_bit_index(N)`. The enum is shared with the decoder-side testbenches.
- Sub-module `prio_enc`:
  - Purely combinational, parameter N.
  - Input: vector. Outputs: W-bit index of the lowest set bit, plus `any`.
  - Instantiated once on `pending`.
- `out_last` is computed as `(pending & (pending - 1)) == 0` while BUSY.

## Test plan
- Reset then single bit: after `rst`, all outputs are at reset values. Send `in` = 8'b0010_0000 with `out_ready` = 1 → next cycle `out` = 5, `out_last` = 1; one cycle later `in_ready` = 1.
- Multi-hot burst: `in` = 8'b1001_0110, `out_ready` = 1 → `out` sequence 1, 2, 4, 7 on consecutive cycles, with `out_last` only on 7.
- Backpressure: `in` = 8'b0000_1001, `out_ready` low for 3 cycles → `out` = 0 held stable with `out_valid` = 1. Then raise `out_ready` → 0, then 3 with `out_last` = 1.
- Zero vector and busy input:
  - `in` = 0 with `in_valid` → no `out_valid`, state stays IDLE.
  - During BUSY, drive `in_valid` with 8'hFF → ignored, `in_ready` = 0.
- Full vector and mid-burst reset:
  - `in` = 8'hFF → indices 0..7, then idle.
  - Repeat, and assert `rst` after index 2 → next cycle `out_valid` = 0, `in_ready` = 1; remaining bits are not emitted.
- Exhaustive: for every `in` 1..255 with random `out_ready`, the emitted index set equals the set bits in ascending order, with exactly one `out_last` per vector.
